// File: rtl/bus_err_pkg.sv
// Shared types and helpers for the bus error drain arbiter.
package bus_err_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } drain_state_e;

    // Same contract as cf_math_pkg::idx_width: a single unit still gets a one-bit index.
    function automatic int unsigned idx_width(input int unsigned num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/bus_err_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last grant and wraps.
module bus_err_rr_pick
    import bus_err_pkg::*;
#(
    parameter int unsigned NumUnits = 4,
    localparam int unsigned IdxW    = idx_width(NumUnits)
) (
    input  logic [NumUnits-1:0] req,
    input  logic [IdxW-1:0]     last,
    output logic [NumUnits-1:0] gnt,
    output logic [IdxW-1:0]     idx
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NumUnits; i++) begin
            cand = IdxW'((32'(last) + i) % NumUnits);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/bus_err_drain_arbiter.sv
// Drains several bus error unit FIFOs round-robin into one registered valid/ready readout.
// Define BUS_ERR_DRAIN_COUNTERS_EN to build per-unit saturating capture counters.
module bus_err_drain_arbiter
    import bus_err_pkg::*;
#(
    parameter int unsigned NumUnits      = 4,
    parameter int unsigned AddrWidth     = 48,
    parameter int unsigned MetaDataWidth = 1,
    parameter int unsigned ErrBits       = 3,
    parameter int unsigned CntWidth      = 8,
    localparam int unsigned IdxW         = idx_width(NumUnits)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NumUnits-1:0]               unit_err_irq_i,
    input  logic [NumUnits*ErrBits-1:0]       unit_err_code_i,
    input  logic [NumUnits*AddrWidth-1:0]     unit_err_addr_i,
    input  logic [NumUnits*MetaDataWidth-1:0] unit_err_meta_i,
    output logic [NumUnits-1:0]               unit_pop_o,
    output logic                              err_valid_o,
    input  logic                              err_ready_i,
    output logic [IdxW-1:0]                   err_unit_o,
    output logic [ErrBits-1:0]                err_code_o,
    output logic [AddrWidth-1:0]              err_addr_o,
    output logic [MetaDataWidth-1:0]          err_meta_o,
    output logic                              irq_o,
    input  logic                              cnt_clear_i,
    output logic [NumUnits*CntWidth-1:0]      err_cnt_o
);

    typedef struct packed {
        logic [IdxW-1:0]          unit;
        logic [ErrBits-1:0]       code;
        logic [AddrWidth-1:0]     addr;
        logic [MetaDataWidth-1:0] meta;
    } err_rec_t;

    drain_state_e        state;
    err_rec_t            rec_p0;
    err_rec_t            rec_p1;
    logic [IdxW-1:0]     last_q;
    logic [IdxW-1:0]     grant_idx;
    logic [NumUnits-1:0] grant;
    logic                capture;

    bus_err_rr_pick #(.NumUnits(NumUnits)) u_pick (
        .req  (unit_err_irq_i),
        .last (last_q),
        .gnt  (grant),
        .idx  (grant_idx)
    );

    // The slot frees up in the same cycle the consumer takes the held record.
    assign capture    = (|unit_err_irq_i) && (state == IDLE || err_ready_i) && !rst_i;
    assign unit_pop_o = capture ? grant : '0;

    // p0: head entry of the granted unit
    always_comb begin
        rec_p0.unit = grant_idx;
        rec_p0.code = unit_err_code_i[32'(grant_idx)*ErrBits +: ErrBits];
        rec_p0.addr = unit_err_addr_i[32'(grant_idx)*AddrWidth +: AddrWidth];
        rec_p0.meta = unit_err_meta_i[32'(grant_idx)*MetaDataWidth +: MetaDataWidth];
    end

    // p1: held record and drain FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            rec_p1 <= '0;
            last_q <= IdxW'(NumUnits - 1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (capture) begin
                        state  <= VALID;
                        rec_p1 <= rec_p0;
                        last_q <= grant_idx;
                    end
                end
                VALID: begin
                    if (capture) begin
                        rec_p1 <= rec_p0;
                        last_q <= grant_idx;
                    end else if (err_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign err_valid_o = (state == VALID);
    assign irq_o       = err_valid_o;
    assign err_unit_o  = rec_p1.unit;
    assign err_code_o  = rec_p1.code;
    assign err_addr_o  = rec_p1.addr;
    assign err_meta_o  = rec_p1.meta;

`ifdef BUS_ERR_DRAIN_COUNTERS_EN
    logic [NumUnits-1:0][CntWidth-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NumUnits; k++) begin
                if (cnt_clear_i) begin
                    cnt_q[k] <= (capture && grant[k]) ? CntWidth'(1) : '0;
                end else if (capture && grant[k] && cnt_q[k] != '1) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign err_cnt_o = cnt_q;
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear_i;
    assign err_cnt_o        = '0;
`endif

endmodule

// File: tb/tb_bus_err_drain_arbiter.sv
// Directed bench for bus_err_drain_arbiter with a per-cycle reference model and literal checks.
module tb_bus_err_drain_arbiter;

    localparam int N       = 4;
    localparam int AW      = 48;
    localparam int MW      = 1;
    localparam int EB      = 3;
    localparam int CW      = 2;
    localparam int IW      = 2;
    localparam int CNT_MAX = 3;

    logic            clk   = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    irq   = '0;
    logic [N*EB-1:0] code  = '0;
    logic [N*AW-1:0] addr  = '0;
    logic [N*MW-1:0] meta  = '0;
    logic            ready = 1'b0;
    logic            clr   = 1'b0;

    logic [N-1:0]    pop;
    logic            valid;
    logic            irq_out;
    logic [IW-1:0]   unit;
    logic [EB-1:0]   ocode;
    logic [AW-1:0]   oaddr;
    logic [MW-1:0]   ometa;
    logic [N*CW-1:0] cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_err_drain_arbiter #(
        .NumUnits(N), .AddrWidth(AW), .MetaDataWidth(MW), .ErrBits(EB), .CntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .unit_err_irq_i(irq), .unit_err_code_i(code), .unit_err_addr_i(addr), .unit_err_meta_i(meta),
        .unit_pop_o(pop), .err_valid_o(valid), .err_ready_i(ready), .err_unit_o(unit),
        .err_code_o(ocode), .err_addr_o(oaddr), .err_meta_o(ometa), .irq_o(irq_out),
        .cnt_clear_i(clr), .err_cnt_o(cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: at most one held record, fair search from the unit after the last winner.
    function automatic int rr_pick(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++)
            if (req[2'((last + k) % N)]) return (last + k) % N;
        return -1;
    endfunction

    bit             m_valid = 1'b0;
    int             m_unit  = 0;
    int             m_last  = N - 1;
    logic [EB-1:0]  m_code  = '0;
    logic [AW-1:0]  m_addr  = '0;
    logic [MW-1:0]  m_meta  = '0;
    int             m_cnt[N] = '{default: 0};
    int             m_g;
    bit             m_cap;
    logic [N-1:0]   exp_pop;

    always_comb begin
        m_g     = rr_pick(irq, m_last);
        m_cap   = !rst_i && (m_g >= 0) && (!m_valid || ready);
        exp_pop = m_cap ? (N'(1) << m_g) : '0;
    end

    always @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            m_valid <= 1'b0;
            m_last  <= N - 1;
            for (int k = 0; k < N; k++) m_cnt[k] <= 0;
        end else begin
            if (m_cap) begin
                m_valid <= 1'b1;
                m_unit  <= m_g;
                m_last  <= m_g;
                m_code  <= code[m_g*EB +: EB];
                m_addr  <= addr[m_g*AW +: AW];
                m_meta  <= meta[m_g*MW +: MW];
            end else if (m_valid && ready) begin
                m_valid <= 1'b0;
            end
`ifdef BUS_ERR_DRAIN_COUNTERS_EN
            for (int k = 0; k < N; k++) begin
                if (clr) m_cnt[k] <= (m_cap && m_g == k) ? 1 : 0;
                else if (m_cap && m_g == k) m_cnt[k] <= (m_cnt[k] >= CNT_MAX) ? CNT_MAX : m_cnt[k] + 1;
            end
`endif
        end
    end

    always @(negedge clk) begin
        chk("pop", 64'(pop), 64'(exp_pop));
        chk("valid", 64'(valid), 64'(m_valid));
        chk("irq", 64'(irq_out), 64'(m_valid));
        if (m_valid) begin
            chk("unit", 64'(unit), 64'(m_unit));
            chk("code", 64'(ocode), 64'(m_code));
            chk("addr", 64'(oaddr), 64'(m_addr));
            chk("meta", 64'(ometa), 64'(m_meta));
        end
        for (int k = 0; k < N; k++) chk("cnt", 64'(cnt[k*CW +: CW]), 64'(m_cnt[k]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    task automatic set_unit(input int u, input logic [EB-1:0] c, input logic [AW-1:0] a, input logic [MW-1:0] m);
        code[u*EB +: EB] = c;
        addr[u*AW +: AW] = a;
        meta[u*MW +: MW] = m;
    endtask

    int fair_order[5] = '{0, 1, 2, 3, 0};
    int npop;
    logic [N*CW-1:0] exp_sat;
    logic [N*CW-1:0] exp_clr;

    initial begin
`ifdef BUS_ERR_DRAIN_COUNTERS_EN
        exp_sat = 8'h0C;
        exp_clr = 8'h04;
`else
        exp_sat = 8'h00;
        exp_clr = 8'h00;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_irq", 64'(irq_out), 64'(0));
        chk("rst_pop", 64'(pop), 64'(0));
        chk("rst_unit", 64'(unit), 64'(0));
        chk("rst_code", 64'(ocode), 64'(0));
        chk("rst_addr", 64'(oaddr), 64'(0));
        chk("rst_meta", 64'(ometa), 64'(0));
        chk("rst_cnt", 64'(cnt), 64'(0));
        rst_i = 1'b0;

        // single request from unit 2, consumer stalled
        irq = 4'b0100;
        set_unit(2, 3'd5, 48'h1234, 1'b1);
        @(negedge clk);
        chk("single_pop", 64'(pop), 64'(4'b0100));
        tick();
        irq = '0;
        set_unit(2, 3'd7, 48'hdead, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(valid), 64'(1));
            chk("hold_unit", 64'(unit), 64'(2));
            chk("hold_code", 64'(ocode), 64'(5));
            chk("hold_addr", 64'(oaddr), 64'(48'h1234));
            chk("hold_pop", 64'(pop), 64'(0));
        end
        tick();
        ready = 1'b1;
        @(negedge clk);
        chk("accept_valid", 64'(valid), 64'(1));
        tick();
        @(negedge clk);
        chk("idle_valid", 64'(valid), 64'(0));
        chk("idle_irq", 64'(irq_out), 64'(0));

        // fairness with all units pending
        do_reset();
        for (int k = 0; k < N; k++) set_unit(k, EB'(k + 1), AW'(32'h100 + k), MW'(k % 2));
        irq   = 4'b1111;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("fair_pop", 64'(pop), 64'(N'(1) << fair_order[i]));
            if (i > 0) chk("fair_unit", 64'(unit), 64'(fair_order[i-1]));
            tick();
        end
        irq = '0;
        @(negedge clk);
        chk("fair_last_unit", 64'(unit), 64'(0));
        chk("fair_last_code", 64'(ocode), 64'(1));
        tick();
        @(negedge clk);
        chk("ret_idle_valid", 64'(valid), 64'(0));
        chk("ret_idle_irq", 64'(irq_out), 64'(0));

        // backpressure with units 1 and 3 pending
        tick();
        irq   = 4'b1010;
        ready = 1'b0;
        npop  = 0;
        @(negedge clk);
        chk("bp_first_pop", 64'(pop), 64'(4'b0010));
        tick();
        irq = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (pop != '0) npop++;
            tick();
        end
        chk("bp_no_extra_pop", 64'(npop), 64'(0));
        ready = 1'b1;
        @(negedge clk);
        chk("bp_second_pop", 64'(pop), 64'(4'b1000));
        chk("bp_unit_held", 64'(unit), 64'(1));
        tick();
        irq = '0;
        @(negedge clk);
        chk("bp_second_unit", 64'(unit), 64'(3));
        tick();
        @(negedge clk);
        chk("bp_idle_valid", 64'(valid), 64'(0));

        // counters: saturation, then clear coinciding with a capture
        do_reset();
        irq = 4'b0010;
        repeat (5) tick();
        irq = '0;
        @(negedge clk);
        chk("cnt_sat", 64'(cnt), 64'(exp_sat));
        tick();
        irq = 4'b0100;
        tick();
        irq = 4'b0010;
        clr = 1'b1;
        tick();
        irq = '0;
        clr = 1'b0;
        @(negedge clk);
        chk("cnt_clear", 64'(cnt), 64'(exp_clr));

        // reset while a record is held and a request is still pending
        tick();
        ready = 1'b0;
        irq   = 4'b0001;
        tick();
        @(negedge clk);
        chk("mid_valid_before", 64'(valid), 64'(1));
        #2;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(valid), 64'(0));
        chk("mid_rst_irq", 64'(irq_out), 64'(0));
        chk("mid_rst_pop", 64'(pop), 64'(0));
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_pop_hold", 64'(pop), 64'(0));
        end
        tick();
        rst_i = 1'b0;
        irq   = '0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_err_drain_arbiter.md
# bus_err_drain_arbiter

Drain controller that shares one software-facing error readout port between `NumUnits` bare bus error units. It round-robin selects a unit with a non-empty error FIFO (its `err_irq_o` is high). It captures that unit's head entry (code, address, metadata) into an output register and pops the unit's FIFO. It then presents the record on a valid/ready port with one combined interrupt. Optional per-unit saturating error counters support statistics.

## Interface
Parameters:
- `NumUnits`, 4 — number of attached bus error units (≥1)
- `AddrWidth`, 48 — error address width
- `MetaDataWidth`, 1 — metadata width
- `ErrBits`, 3 — error code width
- `CntWidth`, 8 — per-unit counter width (only used with counters compiled in)

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` in 1 — clock
- `rst_i` in 1 — asynchronous active-high reset
- `unit_err_irq_i` in `NumUnits` — per-unit "FIFO non-empty"
- `unit_err_code_i` in `NumUnits×ErrBits` — per-unit head error code
- `unit_err_addr_i` in `NumUnits×AddrWidth` — per-unit head address
- `unit_err_meta_i` in `NumUnits×MetaDataWidth` — per-unit head metadata
- `unit_pop_o` out `NumUnits` — one-hot pop strobe to the unit FIFOs
- `err_valid_o` out 1 — captured record valid
- `err_ready_i` in 1 — consumer accepts record
- `err_unit_o` out `idx_width(NumUnits)` — source unit index of the record
- `err_code_o`, `err_addr_o`, `err_meta_o` out (widths as above) — captured record
- `irq_o` out 1 — combined interrupt; equals `err_valid_o`
- `cnt_clear_i` in 1 — synchronous clear of all counters (counters build only)
- `err_cnt_o` out `NumUnits×CntWidth` — per-unit counters (counters build only)

## Operation
- FSM with two states: IDLE (no record held) and VALID (record held, `err_valid_o`=1).
- **Capture event:** a request exists (`|unit_err_irq_i`) AND (state IDLE OR (`VALID` AND `err_ready_i`)).
  - Grant the unit chosen by round-robin.
  - Register the granted unit's code, addr and meta, plus its index.
  - Drive `unit_pop_o[grant]`=1 combinationally in the same cycle. At most one pop bit is high.
  - Next state is VALID.
- VALID with `err_ready_i`=1 and no request: next state is IDLE. Output data registers hold their stale value; the value is don't-care.
- VALID with `err_ready_i`=0: all outputs stable, no pop issued.
- **Round-robin:**
  - `last_q` holds the last granted index.
  - The search starts at `last_q+1` and wraps modulo `NumUnits`.
  - `last_q` updates only on a capture event.
  - `NumUnits`=1 degenerates to always granting unit 0.
- The units' FIFOs are non-fall-through with registered status. After a pop at edge t, `unit_err_irq_i` for that unit is already correct in cycle t+1, so back-to-back grants to the same unit are legal.
- **Reset mid-operation:** any held record is discarded and no pop is issued while `rst_i`=1.

## Timing
- Reset values: `err_valid_o`=0, `irq_o`=0, `unit_pop_o`=0, `err_unit_o`=0, `err_code_o`/`err_addr_o`/`err_meta_o`=0, `last_q`=`NumUnits-1` (so unit 0 wins first), `err_cnt_o`=0.
- **Latency:** request sampled in cycle t; `err_valid_o` is high from cycle t+1.
- **Throughput:** one record per cycle while the consumer holds `err_ready_i`=1 and requests are pending.
- **Handshake:** a record transfers on `err_valid_o & err_ready_i`. Once asserted, `err_valid_o` stays high and the data stays stable until the transfer.
- `unit_pop_o` is combinational from registered state, `unit_err_irq_i` and `err_ready_i`. There is no combinational path from `unit_err_*` data inputs to outputs.

## Configuration
- Macro: `BUS_ERR_DRAIN_COUNTERS_EN`.
- **Defined:**
  - Each unit has a `CntWidth` counter, incremented on every capture from that unit.
  - The counter saturates at all-ones.
  - `cnt_clear_i` zeroes all counters.
  - A clear in the same cycle as a capture from unit k sets counter k to 1 and all other counters to 0.
- **Undefined:** no counter flops. `err_cnt_o` is tied to 0 and `cnt_clear_i` is ignored.

## Structure
- Shared package `bus_err_pkg` holds:
  - the FSM state enum `drain_state_e` {IDLE, VALID}
  - the index-width helper (re-exporting `cf_math_pkg::idx_width`).
- The record struct is typedef'd locally because its widths are parameter-dependent.
- One sub-module: `bus_err_rr_pick`. It takes the request vector and `last_q` and produces the one-hot grant and binary index, purely combinationally.

## Test plan
- **Reset and single request:**
  - Reset, then raise `unit_err_irq_i`=4'b0100 with code 3'd5 and addr 0x1234 for one cycle, `err_ready_i`=0.
  - Required: `unit_pop_o`=4'b0100 for one cycle.
  - Required: next cycle `err_valid_o`=1, `err_unit_o`=2, code 5, addr 0x1234, held stable for 10 cycles.
- **Fairness:**
  - Hold all four irqs high with `err_ready_i`=1.
  - Required: grant order 0,1,2,3,0, with one record per cycle.
- **Backpressure:**
  - Two units pending, `err_ready_i`=0 for 5 cycles.
  - Required: exactly one pop, and no further pop until the ready cycle.
  - Required: the second pop occurs in that same cycle.
- **Return to idle:**
  - Accept the last record with no requests pending.
  - Required: `err_valid_o`=0 and `irq_o`=0 the next cycle.
- **Counters (macro defined), saturation:**
  - With `CntWidth`=2, 5 captures from unit 1.
  - Required: `err_cnt_o[1]`=3.
- **Counters (macro defined), clear during capture:**
  - Assert `cnt_clear_i` during a capture from unit 1.
  - Required: counter 1 = 1, all others 0.
- **Reset mid-operation:**
  - Assert `rst_i` while VALID.
  - Required: `err_valid_o`=0 immediately (asynchronous), and no pops while `rst_i`=1.
